// File: rtl/reg_access_pkg.sv
// Shared types and sizing for the register-access controller slice.
// Holds the FSM state encoding, default widths and the stall-counter helper.
package reg_access_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int NREGS   = 32;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        HOLD
    } state_t;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reg_access_ctrl_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set when a
// writer is issued and cleared when its writeback is accepted.
module reg_scoreboard #(
    parameter int REG_W = reg_access_pkg::REG_W,
    parameter int NREGS = reg_access_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set,
    input  logic [REG_W-1:0] i_set_idx,
    input  logic             i_clr,
    input  logic [REG_W-1:0] i_clr_idx,
    output logic [NREGS-1:0] o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    // Register 0 is hard-wired, so it is never allowed to become busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set && (i_set_idx != '0)) begin
            w_set_mask[i_set_idx] = 1'b1;
        end
        if (i_clr) begin
            w_clr_mask[i_clr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file access controller: accepts decoded instructions, reads their
// operands from a registered-output register file and arbitrates writebacks.
module reg_access_ctrl #(
    parameter int DATA_W = reg_access_pkg::DATA_W,
    parameter int REG_W  = reg_access_pkg::REG_W
) (
    input  logic                                clk,
    input  logic                                rst,
    // decode side
    input  logic                                dec_valid,
    output logic                                dec_ready,
    input  logic [REG_W-1:0]                    dec_rs,
    input  logic [REG_W-1:0]                    dec_rt,
    input  logic [REG_W-1:0]                    dec_rd,
    input  logic                                dec_wen,
    // operand side
    output logic                                op_valid,
    input  logic                                op_ready,
    output logic [DATA_W-1:0]                   op_a,
    output logic [DATA_W-1:0]                   op_b,
    output logic [REG_W-1:0]                    op_rd,
    output logic                                op_wen,
    // writeback side
    input  logic                                wb_valid,
    output logic                                wb_ready,
    input  logic [REG_W-1:0]                    wb_rd,
    input  logic [DATA_W-1:0]                   wb_data,
    // register file side
    output logic [REG_W-1:0]                    rr1,
    output logic [REG_W-1:0]                    rr2,
    output logic [REG_W-1:0]                    wr,
    output logic [DATA_W-1:0]                   wd,
    output logic                                regwr,
    input  logic [DATA_W-1:0]                   rd1,
    input  logic [DATA_W-1:0]                   rd2,
    // status
    output logic [reg_access_pkg::STALL_W-1:0]  stall_cnt
);

    import reg_access_pkg::*;

    state_t               r_state;
    logic [REG_W-1:0]     r_rs;
    logic [REG_W-1:0]     r_rt;
    logic [REG_W-1:0]     r_rd;
    logic                 r_wen;
    logic                 r_op_valid;
    logic [DATA_W-1:0]    r_op_a;
    logic [DATA_W-1:0]    r_op_b;
    logic [REG_W-1:0]     r_op_rd;
    logic                 r_op_wen;
    logic [STALL_W-1:0]   r_stall_cnt;

    logic [NREGS-1:0]     w_busy;
    logic                 w_hazard;
    logic                 w_dec_fire;
    logic                 w_wb_fire;
    logic                 w_sb_set;

    reg_scoreboard #(
        .REG_W (REG_W),
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_sb_set),
        .i_set_idx (dec_rd),
        .i_clr     (w_wb_fire),
        .i_clr_idx (wb_rd),
        .o_busy    (w_busy)
    );

    // Hazard looks only at the registered busy bits; a writeback clearing a
    // bit this cycle is seen by decode one cycle later.
    assign w_hazard = w_busy[dec_rs] | w_busy[dec_rt] | (dec_wen & w_busy[dec_rd]);

    // The register file read port is busy in READ, so writebacks wait there.
    // Gating with rst keeps any write from landing during a reset cycle.
    assign wb_ready   = !rst && (r_state != READ);
    assign w_wb_fire  = wb_valid && wb_ready;

    // Writeback outranks decode: any pending writeback blocks acceptance.
    assign dec_ready  = !rst && (r_state == IDLE) && !wb_valid && !w_hazard;
    assign w_dec_fire = dec_valid && dec_ready;
    assign w_sb_set   = w_dec_fire && dec_wen;

    assign regwr = w_wb_fire;
    assign wr    = w_wb_fire ? wb_rd   : '0;
    assign wd    = w_wb_fire ? wb_data : '0;

    assign rr1 = (r_state == READ) ? r_rs : '0;
    assign rr2 = (r_state == READ) ? r_rt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_wen       <= 1'b0;
            r_op_valid  <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_rd     <= '0;
            r_op_wen    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dec_valid && w_hazard) begin
                        r_stall_cnt <= sat_inc(r_stall_cnt);
                    end
                    if (w_dec_fire) begin
                        r_rs    <= dec_rs;
                        r_rt    <= dec_rt;
                        r_rd    <= dec_rd;
                        r_wen   <= dec_wen;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_op_a     <= rd1;
                    r_op_b     <= rd2;
                    r_op_rd    <= r_rd;
                    r_op_wen   <= r_wen;
                    r_op_valid <= 1'b1;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign op_valid  = r_op_valid;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign op_rd     = r_op_rd;
    assign op_wen    = r_op_wen;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl with a registered-read register file model.
module tb_reg_access_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic          wen;
        logic          do_wb;
        logic [DW-1:0] wb_val;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] rd;
        logic          wen;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid, dec_ready, dec_wen;
    logic [RW-1:0] dec_rs, dec_rt, dec_rd;
    logic          op_valid, op_ready, op_wen;
    logic [DW-1:0] op_a, op_b;
    logic [RW-1:0] op_rd;
    logic          wb_valid, wb_ready;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] rr1, rr2, wr;
    logic [DW-1:0] wd, rd1, rd2;
    logic          regwr;
    logic [15:0]   stall_cnt;

    logic [DW-1:0] rf [32];
    logic          rf_init;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall = 0;
    exp_t q[$];
    vec_t vt[7];

    always #5 clk = ~clk;

    reg_access_ctrl #(
        .DATA_W (DW),
        .REG_W  (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_rs    (dec_rs),
        .dec_rt    (dec_rt),
        .dec_rd    (dec_rd),
        .dec_wen   (dec_wen),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_rd     (op_rd),
        .op_wen    (op_wen),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rr1       (rr1),
        .rr2       (rr2),
        .wr        (wr),
        .wd        (wd),
        .regwr     (regwr),
        .rd1       (rd1),
        .rd2       (rd2),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 0) ? '0 : DW'(32'h121 + i);
    endfunction

    // Register file: reads registered, write lands at the edge closing the regwr cycle.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (regwr) begin
            rf[wr] <= wd;
        end
        rd1 <= rf[rr1];
        rd2 <= rf[rr2];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept_decode(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic [RW-1:0] rd, input logic wen,
                                 input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                                 output int waits);
        exp_t e;
        dec_rs = rs; dec_rt = rt; dec_rd = rd; dec_wen = wen; dec_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!dec_ready && waits < 40) begin
            waits++;
            exp_stall++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        if (!dec_ready) begin
            check("decode_accept", dec_ready, 1);
            dec_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        e.a = ea; e.b = eb; e.rd = rd; e.wen = wen;
        q.push_back(e);
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic complete_op(input int exp_wait, input int hold, input bit do_ready);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!op_valid && n < 10) begin
            n++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("op_valid_latency", n, exp_wait);
        if (!op_valid) begin
            @(posedge clk); #1;
            return;
        end
        if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL op_unexpected: got op_valid with no outstanding decode, expected none");
            @(posedge clk); #1;
            return;
        end
        e = q[0];
        for (int h = 0; h < hold; h++) begin
            check("hold_op_valid", op_valid, 1);
            check("hold_op_a", op_a, e.a);
            check("hold_op_b", op_b, e.b);
            check("hold_op_rd", op_rd, e.rd);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        if (do_ready) begin
            op_ready = 1'b1;
            @(negedge clk);
            check("op_handshake_valid", op_valid, 1);
            e = q.pop_front();
            check("op_a", op_a, e.a);
            check("op_b", op_b, e.b);
            check("op_rd", op_rd, e.rd);
            check("op_wen", op_wen, e.wen);
            @(posedge clk); #1;
            op_ready = 1'b0;
        end
    endtask

    task automatic run_op(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic wen,
                          input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        int w;
        accept_decode(rs, rt, rd, wen, ea, eb, w);
        check("accept_wait", w, 0);
        @(negedge clk);
        check("read_rr1", rr1, rs);
        check("read_rr2", rr2, rt);
        check("read_wb_ready", wb_ready, 0);
        check("read_op_valid", op_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("capture_rr1", rr1, 0);
        check("capture_op_valid", op_valid, 0);
        @(posedge clk); #1;
        complete_op(0, 0, 1'b1);
    endtask

    task automatic do_wb(input logic [RW-1:0] rd, input logic [DW-1:0] data);
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        @(negedge clk);
        check("wb_ready", wb_ready, 1);
        check("wb_regwr", regwr, 1);
        check("wb_wr", wr, rd);
        check("wb_wd", wd, data);
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        int w;

        // rf preload: r0=0, rN = 0x121+N
        vt[0] = '{5'd2,  5'd0,  5'd0,  1'b0, 1'b0, 32'h0,        32'h0000_0123, 32'h0000_0000};
        vt[1] = '{5'd5,  5'd31, 5'd7,  1'b1, 1'b1, 32'hCAFE_0007, 32'h0000_0126, 32'h0000_0140};
        vt[2] = '{5'd7,  5'd2,  5'd0,  1'b0, 1'b0, 32'h0,        32'hCAFE_0007, 32'h0000_0123};
        vt[3] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 32'h5555_AAAA, 32'h0000_0140, 32'h0000_0140};
        vt[4] = '{5'd0,  5'd31, 5'd0,  1'b1, 1'b0, 32'h0,        32'h0000_0000, 32'h5555_AAAA};
        vt[5] = '{5'd3,  5'd30, 5'd1,  1'b0, 1'b0, 32'h0,        32'h0000_0124, 32'h0000_013F};
        vt[6] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 32'h0,        32'h0000_0000, 32'h0000_0000};

        rst = 1'b1; rf_init = 1'b1;
        dec_valid = 1'b0; dec_rs = '0; dec_rt = '0; dec_rd = '0; dec_wen = 1'b0;
        op_ready = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rf_init = 1'b0;
        @(negedge clk);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_rd", op_rd, 0);
        check("rst_op_wen", op_wen, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_regwr", regwr, 0);
        check("rst_dec_ready", dec_ready, 0);
        check("rst_rr1", rr1, 0);
        @(posedge clk); #1;
        rst = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check("idle_dec_ready", dec_ready, 1);
        check("idle_wb_ready", wb_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].wen, vt[i].exp_a, vt[i].exp_b);
            if (vt[i].do_wb) do_wb(vt[i].rd, vt[i].wb_val);
        end
        check("table_stall_cnt", stall_cnt, exp_stall);

        // RAW hazard on r4: stalls until the writeback lands
        run_op(5'd1, 5'd2, 5'd4, 1'b1, 32'h0000_0122, 32'h0000_0123);
        dec_valid = 1'b1; dec_rs = 5'd4; dec_rt = 5'd0; dec_rd = 5'd0; dec_wen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_dec_ready", dec_ready, 0);
            check("stall_cnt_run", stall_cnt, exp_stall);
            exp_stall++;
            @(posedge clk); #1;
        end
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_DEAD;
        @(negedge clk);
        check("stall_wb_dec_ready", dec_ready, 0);
        check("stall_wb_regwr", regwr, 1);
        check("stall_wb_wr", wr, 4);
        check("stall_wb_cnt", stall_cnt, exp_stall);
        exp_stall++;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        run_op(5'd4, 5'd0, 5'd0, 1'b0, 32'h0000_DEAD, 32'h0);
        check("stall_cnt_total", stall_cnt, exp_stall);

        // writeback arriving during READ is held off until CAPTURE
        accept_decode(5'd4, 5'd9, 5'd0, 1'b0, 32'h0000_DEAD, 32'h0000_012A, w);
        check("rdwb_accept_wait", w, 0);
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_9999;
        @(negedge clk);
        check("rdwb_read_wb_ready", wb_ready, 0);
        check("rdwb_read_regwr", regwr, 0);
        check("rdwb_read_wr", wr, 0);
        check("rdwb_read_rr2", rr2, 9);
        @(posedge clk); #1;
        @(negedge clk);
        check("rdwb_cap_wb_ready", wb_ready, 1);
        check("rdwb_cap_regwr", regwr, 1);
        check("rdwb_cap_wr", wr, 9);
        check("rdwb_cap_wd", wd, 32'h9999_9999);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        complete_op(0, 0, 1'b1);

        // simultaneous decode and writeback: write first, decode next cycle
        dec_valid = 1'b1; dec_rs = 5'd9; dec_rt = 5'd4; dec_rd = 5'd0; dec_wen = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h0C0C_0C0C;
        @(negedge clk);
        check("prio_dec_ready", dec_ready, 0);
        check("prio_regwr", regwr, 1);
        check("prio_wr", wr, 12);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        run_op(5'd9, 5'd4, 5'd0, 1'b0, 32'h9999_9999, 32'h0000_DEAD);

        // stall in HOLD for 5 cycles, then reset while holding
        accept_decode(5'd12, 5'd0, 5'd6, 1'b1, 32'h0C0C_0C0C, 32'h0, w);
        check("hold_accept_wait", w, 0);
        complete_op(2, 5, 1'b0);
        rst = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_0BAD;
        @(negedge clk);
        check("midrst_regwr", regwr, 0);
        check("midrst_dec_ready", dec_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; wb_valid = 1'b0;
        q.delete();
        exp_stall = 0;
        @(negedge clk);
        check("midrst_op_valid", op_valid, 0);
        check("midrst_op_a", op_a, 0);
        check("midrst_op_b", op_b, 0);
        check("midrst_op_rd", op_rd, 0);
        check("midrst_op_wen", op_wen, 0);
        check("midrst_stall_cnt", stall_cnt, exp_stall);
        check("midrst_dec_ready", dec_ready, 1);
        @(posedge clk); #1;
        run_op(5'd6, 5'd0, 5'd0, 1'b0, 32'h0000_0127, 32'h0);

        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, register data width; REG_W, default 5, register index width.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have decode-side ports: dec_valid in 1; dec_ready out 1; dec_rs in REG_W; dec_rt in REG_W; dec_rd in REG_W; dec_wen in 1 (instruction will write dec_rd).
REQ-005 SHALL have operand-side ports: op_valid out 1; op_ready in 1; op_a out DATA_W; op_b out DATA_W; op_rd out REG_W; op_wen out 1.
REQ-006 SHALL have writeback-side ports: wb_valid in 1; wb_ready out 1; wb_rd in REG_W; wb_data in DATA_W.
REQ-007 SHALL have register-file-side ports: rr1 out REG_W; rr2 out REG_W; wr out REG_W; wd out DATA_W; regwr out 1; rd1 in DATA_W; rd2 in DATA_W.
REQ-008 SHALL have status port: stall_cnt out 16, hazard stall cycles.

Function
REQ-009 SHALL act as sole initiator of the register file: rd1/rd2 are registered in the file and are valid in the cycle after rr1/rr2 are driven with regwr=0; a write lands at the edge ending the cycle with regwr=1.
REQ-010 SHALL implement FSM states IDLE, READ, CAPTURE, HOLD.
REQ-011 IDLE: dec_ready=1 only if wb_valid=0 and no hazard; on dec_valid&&dec_ready latch rs/rt/rd/wen, go READ.
REQ-012 READ: drive rr1/rr2 from latched rs/rt; regwr=0; wb_ready=0; go CAPTURE.
REQ-013 CAPTURE: register rd1->op_a, rd2->op_b at the closing edge; go HOLD.
REQ-014 HOLD: op_valid=1, op_a/op_b/op_rd/op_wen stable; on op_ready go IDLE.
REQ-015 Latency: decode handshake in cycle C0 -> op_valid first high in cycle C3.
REQ-016 wb_ready SHALL be 1 in IDLE, CAPTURE, HOLD and 0 in READ.
REQ-017 On wb_valid&&wb_ready: regwr=1, wr=wb_rd, wd=wb_data, same cycle (combinational); otherwise regwr=0, wr=0, wd=0.
REQ-018 In IDLE, a writeback SHALL take priority over decode acceptance in the same cycle.
REQ-019 SHALL keep 32-bit busy scoreboard: bit dec_rd set on decode accept when dec_wen=1 and dec_rd!=0; bit wb_rd cleared on writeback accept.
REQ-020 Hazard = busy[dec_rs] or busy[dec_rt] or (dec_wen and busy[dec_rd]), evaluated on registered busy (no same-cycle clear bypass).
REQ-021 Writeback to a non-busy register SHALL still write; busy unchanged.
REQ-022 Register 0 SHALL never be marked busy.
REQ-023 stall_cnt SHALL increment, saturating at 0xFFFF, each IDLE cycle with dec_valid=1 and hazard=1.
REQ-024 rr1/rr2 SHALL be 0 outside READ.

Reset
REQ-025 On rst: state=IDLE, busy=0, op_valid=0, op_a=op_b=0, op_rd=0, op_wen=0, stall_cnt=0; regwr=0 that cycle.
REQ-026 Reset mid-operation SHALL discard latched/captured operands; no writeback is issued during a reset cycle.

Structure
REQ-027 Package reg_access_pkg SHALL hold state enum, DATA_W, REG_W, NREGS=32.
REQ-028 Scoreboard SHALL be sub-module reg_scoreboard (set/clear ports, busy vector out).

Verification
REQ-029 Decode rs=2, rt=0, no busy; file r2=0x123 -> op_valid in C3, op_a=0x00000123, op_b=0.
REQ-030 Decode rd=4 wen=1, then decode rs=4 -> second stalls (dec_ready=0, stall_cnt counts); wb rd=4 data=0xDEAD -> next IDLE accepts, op_a=0xDEAD.
REQ-031 wb_valid asserted during READ -> wb_ready=0, regwr=0; write issued in CAPTURE; captured operands unaffected.
REQ-032 Simultaneous dec_valid and wb_valid in IDLE -> write first, decode accepted next cycle.
REQ-033 op_ready held 0 for 5 cycles in HOLD -> op outputs stable; rst asserted in HOLD -> op_valid=0, busy=0 next cycle.
